// File: rtl/msk_rnd_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : msk_rnd_gen_if
// Purpose  : Seed-stream and random-output bundle of msk_rnd_gen.
// Revision : 1.0
// ============================================================================
interface msk_rnd_gen_if #(
  parameter int RND_W = 1
) ();
  logic [31:0]      seed_in;
  logic             seed_valid;
  logic             seed_ready;
  logic             rnd_en;
  logic             rnd_valid;
  logic [RND_W-1:0] rnd_ref;
  logic [RND_W-1:0] rnd_mul;
  logic             reseed_req;

  modport master (
    output seed_in, seed_valid, rnd_en,
    input  seed_ready, rnd_valid, rnd_ref, rnd_mul, reseed_req
  );

  modport slave (
    input  seed_in, seed_valid, rnd_en,
    output seed_ready, rnd_valid, rnd_ref, rnd_mul, reseed_req
  );
endinterface
`default_nettype wire

// File: rtl/msk_rnd_gen.sv
`default_nettype none
// ============================================================================
// Module   : msk_rnd_gen
// Purpose  : Bank of 2*RND_W 31-bit LFSRs feeding rnd_ref/rnd_mul of masked
//            gadgets; optional periodic reseeding via MSKRND_RESEED_EN.
// Revision : 1.0
// ============================================================================
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_rnd_gen #(
  parameter int d          = `DEFAULTSHARES,
  parameter int RND_W      = 1,
  parameter int WARMUP_CYC = 32,
  parameter int RESEED_PER = 1024
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  msk_rnd_gen_if.slave bus
);

  localparam int NL    = 2 * RND_W;
  localparam int IDX_W = $clog2(NL);
  localparam int WC_W  = $clog2(WARMUP_CYC + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NL - 1);
  localparam logic [WC_W-1:0]  WARM_END = WC_W'(WARMUP_CYC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEED = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  // Share count only documents the consumer; nothing here depends on it.
  generate
    if (d < 1 || WARMUP_CYC < 1 || RESEED_PER < 1) begin : g_cfg_check
    end
  endgenerate

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WC_W-1:0]  warm_cnt;
  logic [30:0]      lfsr [NL];

  logic             seed_rdy;
  logic             rs_req;
  logic             seed_fire;
  logic             last_word;
  logic             bank_step;
  logic [30:0]      seed_word;
  logic             seed_unused;
  logic [RND_W-1:0] ref_bits;
  logic [RND_W-1:0] mul_bits;

  function automatic logic [30:0] lfsr_step(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  function automatic logic [30:0] nz(input logic [30:0] s);
    return (s == 31'd0) ? 31'd1 : s;
  endfunction

  assign seed_word   = bus.seed_in[30:0];
  assign seed_unused = bus.seed_in[31];
  assign seed_fire   = bus.seed_valid & seed_rdy;
  assign last_word   = (idx == IDX_LAST);
  assign bank_step   = ((state == ST_WARM) && (warm_cnt != WARM_END)) ||
                       ((state == ST_RUN) && bus.rnd_en);

`ifdef MSKRND_RESEED_EN
  localparam logic [15:0] RS_TGT = 16'(RESEED_PER);

  logic [15:0] rs_cnt;

  // Saturates at RS_TGT and holds there until the reseed's last word lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (seed_fire && last_word) begin
        rs_cnt <= '0;
      end else if (bus.rnd_en && (rs_cnt != RS_TGT)) begin
        rs_cnt <= rs_cnt + 16'd1;
      end
    end
  end

  assign rs_req = (state == ST_RUN) && (rs_cnt == RS_TGT);
`else
  assign rs_req = 1'b0;
`endif

  assign seed_rdy = (state == ST_SEED) || rs_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      warm_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_SEED;
        ST_SEED: begin
          if (seed_fire) begin
            if (last_word) begin
              idx      <= '0;
              warm_cnt <= '0;
              state    <= ST_WARM;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        // One idle cycle after the last step lets valid rise WARMUP_CYC+1 after seeding.
        ST_WARM: begin
          if (warm_cnt == WARM_END) begin
            state <= ST_RUN;
          end else begin
            warm_cnt <= warm_cnt + WC_W'(1);
          end
        end
        ST_RUN: begin
          if (seed_fire) begin
            idx <= last_word ? '0 : idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        lfsr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (seed_fire && (idx == IDX_W'(i))) begin
`ifdef MSKRND_RESEED_EN
          lfsr[i] <= nz((state == ST_RUN) ? (lfsr_step(lfsr[i]) ^ seed_word) : seed_word);
`else
          lfsr[i] <= nz(seed_word);
`endif
        end else if (bank_step) begin
          lfsr[i] <= lfsr_step(lfsr[i]);
        end
      end
    end
  end

  always_comb begin
    ref_bits = '0;
    mul_bits = '0;
    for (int i = 0; i < RND_W; i++) begin
      ref_bits[i] = lfsr[i][30];
      mul_bits[i] = lfsr[RND_W + i][30];
    end
  end

  assign bus.rnd_ref    = ref_bits;
  assign bus.rnd_mul    = mul_bits;
  assign bus.rnd_valid  = (state == ST_RUN);
  assign bus.seed_ready = seed_rdy;
  assign bus.reseed_req = rs_req;

endmodule
`default_nettype wire

// File: tb/tb_msk_rnd_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_msk_rnd_gen
// Purpose  : Randomized bench for msk_rnd_gen against a behavioural bank model.
// Revision : 1.0
// ============================================================================
module tb_msk_rnd_gen;
  localparam int RND_W      = 4;
  localparam int WARMUP_CYC = 4;
  localparam int RESEED_PER = 8;
  localparam int NL         = 2 * RND_W;
`ifdef MSKRND_RESEED_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  msk_rnd_gen_if #(.RND_W(RND_W)) bus ();

  msk_rnd_gen #(
    .d          (2),
    .RND_W      (RND_W),
    .WARMUP_CYC (WARMUP_CYC),
    .RESEED_PER (RESEED_PER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] lstep(input logic [30:0] s);
    logic fb;
    fb = s[30] ^ s[27];
    return (s << 1) | 31'(fb);
  endfunction

  function automatic logic [30:0] nz(input logic [30:0] s);
    return (s == 31'd0) ? 31'd1 : s;
  endfunction

  // Behavioural model: words received, cycles since seeding finished, run steps.
  logic [30:0]      m_lfsr [NL];
  bit               m_started;
  bit               m_done;
  int               m_words;
  int               m_el;
  int               m_runsteps;
  logic             exp_valid, exp_req, exp_ready, m_fire;
  logic [RND_W-1:0] exp_ref, exp_mul;

  always_comb begin
    exp_valid = m_done && (m_el > WARMUP_CYC);
    exp_req   = RS_EN && exp_valid && (m_runsteps == RESEED_PER);
    exp_ready = (m_started && !m_done) || exp_req;
    exp_ref   = '0;
    exp_mul   = '0;
    for (int i = 0; i < RND_W; i++) begin
      exp_ref[i] = m_lfsr[i][30];
      exp_mul[i] = m_lfsr[RND_W + i][30];
    end
  end

  assign m_fire = bus.seed_valid && exp_req;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) m_lfsr[i] <= '0;
      m_started  <= 1'b0;
      m_done     <= 1'b0;
      m_words    <= 0;
      m_el       <= 0;
      m_runsteps <= 0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_done) begin
      if (bus.seed_valid) begin
        m_lfsr[m_words] <= nz(bus.seed_in[30:0]);
        if (m_words == NL - 1) begin
          m_done  <= 1'b1;
          m_words <= 0;
          m_el    <= 0;
        end else begin
          m_words <= m_words + 1;
        end
      end
    end else if (m_el < WARMUP_CYC) begin
      for (int i = 0; i < NL; i++) m_lfsr[i] <= lstep(m_lfsr[i]);
      m_el <= m_el + 1;
    end else if (m_el == WARMUP_CYC) begin
      m_el <= m_el + 1;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (m_fire && (i == m_words)) m_lfsr[i] <= nz(lstep(m_lfsr[i]) ^ bus.seed_in[30:0]);
        else if (bus.rnd_en) m_lfsr[i] <= lstep(m_lfsr[i]);
      end
      if (m_fire) begin
        if (m_words == NL - 1) begin
          m_words    <= 0;
          m_runsteps <= 0;
        end else begin
          m_words <= m_words + 1;
        end
      end else if (bus.rnd_en && (m_runsteps < RESEED_PER)) begin
        m_runsteps <= m_runsteps + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("rnd_valid",  64'(bus.rnd_valid),  64'(exp_valid));
    check("seed_ready", 64'(bus.seed_ready), 64'(exp_ready));
    check("reseed_req", 64'(bus.reseed_req), 64'(exp_req));
    check("rnd_ref",    64'(bus.rnd_ref),    64'(exp_ref));
    check("rnd_mul",    64'(bus.rnd_mul),    64'(exp_mul));
  end

  logic [31:0]        words [NL];
  logic [2*RND_W-1:0] seq1 [20];
  logic [2*RND_W-1:0] held;
  int                 n;

  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send_words();
    for (int k = 0; k < NL; k++) begin
      bus.seed_in    = words[k];
      bus.seed_valid = 1'b1;
      tick(1);
    end
    bus.seed_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.rnd_valid && cyc < 50) begin
      tick(1);
      cyc++;
    end
  endtask

  initial begin
    bus.seed_in    = '0;
    bus.seed_valid = 1'b0;
    bus.rnd_en     = 1'b0;
    #1 rst_n = 1'b0;
    tick(3);
    check("reset_valid", 64'(bus.rnd_valid), 64'(1'b0));
    check("reset_ready", 64'(bus.seed_ready), 64'(1'b0));
    check("reset_ref",   64'(bus.rnd_ref), 64'(0));
    rst_n = 1'b1;
    tick(1);
    check("first_edge_ready", 64'(bus.seed_ready), 64'(1'b1));

    // No seed yet: rnd_en must not disturb anything.
    bus.rnd_en = 1'b1;
    tick(20);
    check("noseed_ref",   64'(bus.rnd_ref), 64'(0));
    check("noseed_mul",   64'(bus.rnd_mul), 64'(0));
    check("noseed_valid", 64'(bus.rnd_valid), 64'(1'b0));
    bus.rnd_en = 1'b0;

    words[0] = 32'h4000_0000;
    words[1] = 32'h0000_0000;
    for (int k = 2; k < NL; k++) words[k] = $urandom;
    words[NL-1][31] = 1'b1;
    send_words();
    wait_valid(n);
    check("valid_latency", 64'(n), 64'(5));
    check("model_lfsr0",   64'(m_lfsr[0]), 64'(31'h8));
    check("model_lfsr1",   64'(m_lfsr[1]), 64'(31'h10));
    check("run0_ref0",     64'(bus.rnd_ref[0]), 64'(1'b0));
    for (int k = 0; k < 20; k++) begin
      seq1[k]    = {exp_ref, exp_mul};
      bus.rnd_en = 1'b1;
      tick(1);
    end
    bus.rnd_en = 1'b0;

    held = {exp_ref, exp_mul};
    tick(10);
    check("hold_outputs", 64'({bus.rnd_ref, bus.rnd_mul}), 64'(held));
    bus.rnd_en = 1'b1;
    tick(1);
    bus.rnd_en = 1'b0;

    // Reset during warm-up, then replay the same seed.
    do_reset();
    send_words();
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check("warmrst_valid", 64'(bus.rnd_valid), 64'(1'b0));
    rst_n = 1'b1;
    tick(1);
    check("warmrst_ready", 64'(bus.seed_ready), 64'(1'b1));
    check("warmrst_valid2", 64'(bus.rnd_valid), 64'(1'b0));
    send_words();
    wait_valid(n);
    check("valid_latency2", 64'(n), 64'(5));
    for (int k = 0; k < 20; k++) begin
      check("replay_seq", 64'({bus.rnd_ref, bus.rnd_mul}), 64'(seq1[k]));
      bus.rnd_en = 1'b1;
      tick(1);
    end
    bus.rnd_en = 1'b0;

    // Reseed request after RESEED_PER steps (stays low without the option).
    do_reset();
    for (int k = 0; k < NL; k++) words[k] = $urandom;
    send_words();
    wait_valid(n);
    check("valid_latency3", 64'(n), 64'(5));
    bus.rnd_en = 1'b1;
    tick(RESEED_PER - 1);
    check("req_before", 64'(bus.reseed_req), 64'(1'b0));
    tick(1);
    bus.rnd_en = 1'b0;
    check("req_after",   64'(bus.reseed_req), 64'(RS_EN));
    check("ready_after", 64'(bus.seed_ready), 64'(RS_EN));
    for (int k = 0; k < NL; k++) begin
      bus.seed_in    = $urandom;
      bus.seed_valid = 1'b1;
      bus.rnd_en     = 1'($urandom_range(0, 1));
      tick(1);
      check("reseed_valid", 64'(bus.rnd_valid), 64'(1'b1));
    end
    bus.seed_valid = 1'b0;
    bus.rnd_en     = 1'b0;
    check("req_cleared",   64'(bus.reseed_req), 64'(1'b0));
    check("ready_cleared", 64'(bus.seed_ready), 64'(1'b0));

    // Long randomized run.
    for (int k = 0; k < 1000; k++) begin
      bus.rnd_en     = ($urandom_range(0, 3) != 0);
      bus.seed_valid = ($urandom_range(0, 7) == 0);
      bus.seed_in    = $urandom;
      tick(1);
    end
    bus.rnd_en     = 1'b0;
    bus.seed_valid = 1'b0;
    tick(1);
    check("final_valid", 64'(bus.rnd_valid), 64'(1'b1));
    for (int i = 0; i < NL; i++) check("model_nonzero", 64'(m_lfsr[i] != 31'd0), 64'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
